// File: rtl/bomb_pkg.sv
// Shared types and constants for the bomb blast scheduler: FSM states,
// blast pattern indices and the screen coordinate width.
package bomb_pkg;

    localparam int COORD_W = 11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FUSE     = 2'd1,
        BLAST    = 2'd2,
        COOLDOWN = 2'd3
    } state_t;

    localparam logic [2:0] REGULAR    = 3'd0;
    localparam logic [2:0] VERTICAL   = 3'd1;
    localparam logic [2:0] HORIZONTAL = 3'd2;

    // Values above the last defined pattern collapse to the regular blast.
    function automatic logic [2:0] map_pattern(input logic [2:0] rnd);
        return (rnd <= HORIZONTAL) ? rnd : REGULAR;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter: combinational one-hot grant, pointer
// moves to the losing side whenever the owner accepts a grant.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       resetN,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (req == 2'b11)
            grant = ptr ? 2'b10 : 2'b01;
        else
            grant = req;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)
            ptr <= 1'b0;
        else if (advance && (grant != 2'b00))
            ptr <= grant[0];
    end

endmodule

// File: rtl/blast_scheduler.sv
// Bomb blast scheduler: arbitrates bomb requests, runs fuse and blast timers
// on frame ticks. Optional one-entry pending buffer under `BLAST_QUEUE_EN.
//
// state    | meaning
// IDLE     | waiting for a request
// FUSE     | fuse burning, counting frames
// BLAST    | blast displayed, counting frames
// COOLDOWN | single cycle, done pulse
module blast_scheduler
    import bomb_pkg::*;
#(
    parameter int FUSE_FRAMES  = 120,
    parameter int BLAST_FRAMES = 30
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               clear,
    input  logic [1:0]         req,
    input  logic [COORD_W-1:0] reqX0,
    input  logic [COORD_W-1:0] reqY0,
    input  logic [COORD_W-1:0] reqX1,
    input  logic [COORD_W-1:0] reqY1,
    input  logic [2:0]         random_num,
    output logic [1:0]         grant,
    output logic               fuse_active,
    output logic               blast,
    output logic [2:0]         blast_num,
    output logic [COORD_W-1:0] blastX,
    output logic [COORD_W-1:0] blastY,
    output logic               busy,
    output logic               done
);

    localparam logic [7:0] FUSE_LAST  = 8'(FUSE_FRAMES - 1);
    localparam logic [7:0] BLAST_LAST = 8'(BLAST_FRAMES - 1);

    state_t             state, state_n;
    logic [7:0]         cnt, cnt_n;
    logic [1:0]         req_eff, arb_grant, grant_n;
    logic               take, load_new;
    logic [COORD_W-1:0] sel_x, sel_y;
    logic [2:0]         sel_num;

    // A requester still sees its grant this cycle and has not yet dropped req.
    assign req_eff = req & ~grant;

    rr_arbiter2 u_arb (
        .clk     (clk),
        .resetN  (resetN),
        .req     (req_eff),
        .advance (take),
        .grant   (arb_grant)
    );

    assign sel_x   = arb_grant[1] ? reqX1 : reqX0;
    assign sel_y   = arb_grant[1] ? reqY1 : reqY0;
    assign sel_num = map_pattern(random_num);

`ifdef BLAST_QUEUE_EN
    logic               pend_valid;
    logic [COORD_W-1:0] pend_x, pend_y;
    logic [2:0]         pend_num;
    logic               store_pend, load_pend;
`endif

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        take     = 1'b0;
        load_new = 1'b0;
`ifdef BLAST_QUEUE_EN
        store_pend = 1'b0;
        load_pend  = 1'b0;
`endif
        if (clear) begin
            state_n = IDLE;
            cnt_n   = 8'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req_eff != 2'b00) begin
                        take     = 1'b1;
                        load_new = 1'b1;
                        state_n  = FUSE;
                        cnt_n    = 8'd0;
                    end
                end
                FUSE: begin
                    if (startOfFrame) begin
                        if (cnt == FUSE_LAST) begin
                            state_n = BLAST;
                            cnt_n   = 8'd0;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                BLAST: begin
                    if (startOfFrame) begin
                        if (cnt == BLAST_LAST) begin
                            state_n = COOLDOWN;
                            cnt_n   = 8'd0;
                        end else begin
                            cnt_n = cnt + 8'd1;
                        end
                    end
                end
                COOLDOWN: begin
                    state_n = IDLE;
                    cnt_n   = 8'd0;
`ifdef BLAST_QUEUE_EN
                    if (pend_valid) begin
                        load_pend = 1'b1;
                        state_n   = FUSE;
                    end else if (req_eff != 2'b00) begin
                        take     = 1'b1;
                        load_new = 1'b1;
                        state_n  = FUSE;
                    end
`endif
                end
                default: state_n = IDLE;
            endcase
`ifdef BLAST_QUEUE_EN
            if ((state == FUSE || state == BLAST) && !pend_valid && (req_eff != 2'b00)) begin
                take       = 1'b1;
                store_pend = 1'b1;
            end
`endif
        end
        grant_n = take ? arb_grant : 2'b00;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            grant     <= 2'b00;
            blast_num <= REGULAR;
            blastX    <= '0;
            blastY    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            grant <= grant_n;
            if (load_new) begin
                blast_num <= sel_num;
                blastX    <= sel_x;
                blastY    <= sel_y;
            end
`ifdef BLAST_QUEUE_EN
            // Queued bombs publish their position only when their own fuse starts.
            if (load_pend) begin
                blast_num <= pend_num;
                blastX    <= pend_x;
                blastY    <= pend_y;
            end
`endif
        end
    end

`ifdef BLAST_QUEUE_EN
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            pend_valid <= 1'b0;
            pend_x     <= '0;
            pend_y     <= '0;
            pend_num   <= REGULAR;
        end else if (clear) begin
            pend_valid <= 1'b0;
        end else if (store_pend) begin
            pend_valid <= 1'b1;
            pend_x     <= sel_x;
            pend_y     <= sel_y;
            pend_num   <= sel_num;
        end else if (load_pend) begin
            pend_valid <= 1'b0;
        end
    end
`endif

    assign fuse_active = (state == FUSE);
    assign blast       = (state == BLAST);
    assign busy        = (state != IDLE);
    assign done        = (state == COOLDOWN) && !clear;

endmodule

// File: tb/tb_blast_scheduler.sv
// Directed self-checking bench for blast_scheduler with short fuse/blast
// timers (3 and 2 frames).
module tb_blast_scheduler;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        startOfFrame = 1'b0;
    logic        clear = 1'b0;
    logic [1:0]  req = 2'b00;
    logic [10:0] reqX0 = '0, reqY0 = '0, reqX1 = '0, reqY1 = '0;
    logic [2:0]  random_num = 3'd0;
    logic [1:0]  grant;
    logic        fuse_active, blast, busy, done;
    logic [2:0]  blast_num;
    logic [10:0] blastX, blastY;

    int checks = 0;
    int failures = 0;

    blast_scheduler #(.FUSE_FRAMES(3), .BLAST_FRAMES(2)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .clear        (clear),
        .req          (req),
        .reqX0        (reqX0),
        .reqY0        (reqY0),
        .reqX1        (reqX1),
        .reqY1        (reqY1),
        .random_num   (random_num),
        .grant        (grant),
        .fuse_active  (fuse_active),
        .blast        (blast),
        .blast_num    (blast_num),
        .blastX       (blastX),
        .blastY       (blastY),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        step();
        startOfFrame = 1'b0;
    endtask

    task automatic reset_dut();
        resetN = 1'b0;
        step();
        step();
        resetN = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset values
        #3;
        check_val("rst_grant", grant, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_blast", blast, 0);
        check_val("rst_num", blast_num, 0);
        check_val("rst_x", blastX, 0);
        step();
        resetN = 1'b1;

        // Single request, pattern 2, full sequence
        reqX0 = 11'd100; reqY0 = 11'd200; random_num = 3'd2; req = 2'b01;
        step();
        check_val("s1_grant", grant, 2'b01);
        check_val("s1_fuse", fuse_active, 1);
        check_val("s1_num", blast_num, 2);
        check_val("s1_x", blastX, 100);
        check_val("s1_y", blastY, 200);
        req = 2'b00; random_num = 3'd7;
        step();
        check_val("s1_grant_pulse", grant, 0);
        sof(); sof();
        check_val("s1_blast_early", blast, 0);
        sof();
        check_val("s1_blast_rise", blast, 1);
        check_val("s1_num_hold", blast_num, 2);
        sof();
        check_val("s1_blast_hold", blast, 1);
        sof();
        check_val("s1_blast_fall", blast, 0);
        check_val("s1_done", done, 1);
        step();
        check_val("s1_done_once", done, 0);
        check_val("s1_idle", busy, 0);
        sof();
        check_val("s1_sof_idle", busy, 0);

        // Tie after reset, pattern 5 maps to 0, second requester held in FUSE
        reset_dut();
        reqX0 = 11'd100; reqY0 = 11'd20; reqX1 = 11'd300; reqY1 = 11'd40;
        random_num = 3'd5; req = 2'b11;
        step();
        check_val("s2_tie1", grant, 2'b01);
        check_val("s2_num_map", blast_num, 0);
        check_val("s2_x", blastX, 100);
        req = 2'b10;
        step();
`ifdef BLAST_QUEUE_EN
        check_val("s2_queue_grant", grant, 2'b10);
`else
        check_val("s2_no_grant", grant, 2'b00);
`endif
        req = 2'b00; random_num = 3'd1;
        sof(); sof(); sof();
        check_val("s2_blast", blast, 1);
        check_val("s2_num_blast", blast_num, 0);
        check_val("s2_x_hold", blastX, 100);
        sof(); sof();
        check_val("s2_done", done, 1);
        step();
`ifdef BLAST_QUEUE_EN
        check_val("s2_q_fuse", fuse_active, 1);
        check_val("s2_q_x", blastX, 300);
        check_val("s2_q_num", blast_num, 0);
        reset_dut();
`else
        check_val("s2_idle", busy, 0);
        req = 2'b11; random_num = 3'd1;
        step();
        check_val("s2_tie2", grant, 2'b10);
        check_val("s2_x1", blastX, 300);
        check_val("s2_num1", blast_num, 1);
        req = 2'b00;
        reset_dut();
`endif

        // Clear during BLAST
        reqX0 = 11'd55; req = 2'b01;
        step();
        req = 2'b00;
        sof(); sof(); sof();
        check_val("s3_blast", blast, 1);
        clear = 1'b1;
        step();
        check_val("s3_blast_clr", blast, 0);
        check_val("s3_busy_clr", busy, 0);
        check_val("s3_done_clr", done, 0);
        check_val("s3_x_keep", blastX, 55);
        clear = 1'b0;
        step();
        check_val("s3_done_after", done, 0);
        check_val("s3_busy_after", busy, 0);

        // Asynchronous reset mid-FUSE
        reqX0 = 11'd77; reqY0 = 11'd88; random_num = 3'd2; req = 2'b01;
        step();
        req = 2'b00;
        sof();
        check_val("s4_fuse", fuse_active, 1);
        #2;
        resetN = 1'b0;
        #1;
        check_val("s4_fuse_rst", fuse_active, 0);
        check_val("s4_busy_rst", busy, 0);
        check_val("s4_num_rst", blast_num, 0);
        check_val("s4_x_rst", blastX, 0);
        check_val("s4_y_rst", blastY, 0);
        check_val("s4_grant_rst", grant, 0);
        check_val("s4_done_rst", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
